// File: rtl/audio_sequencer_if.sv
// CPU-side configuration/control bus and audio_unit write port of the note sequencer.
// The sequencer is the slave; the CPU/audio_unit environment is the master.
interface audio_sequencer_if #(
    parameter int DEPTH        = 64,
    parameter int PERIOD_WIDTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic                    cfg_wenable;
    logic [AW-1:0]           cfg_addr;
    logic [31:0]             cfg_wdata;
    logic                    start;
    logic                    stop;
    logic                    loop;
    logic                    au_wenable;
    logic [1:0]              au_addr;
    logic [PERIOD_WIDTH-1:0] au_wdata;
    logic                    busy;
    logic [AW-1:0]           step_idx;

    modport master (
        output cfg_wenable, cfg_addr, cfg_wdata, start, stop, loop,
        input  au_wenable, au_addr, au_wdata, busy, step_idx
    );

    modport slave (
        input  cfg_wenable, cfg_addr, cfg_wdata, start, stop, loop,
        output au_wenable, au_addr, au_wdata, busy, step_idx
    );
endinterface

// File: rtl/audio_sequencer.sv
// Autonomous note sequencer: walks a CPU-loaded step table and writes one audio_unit
// period per step, waiting dur*TICK_DIV cycles between steps; ends with a silence sweep.
module audio_sequencer #(
    parameter int NUM_CHANNELS = 4,
    parameter int PERIOD_WIDTH = 16,
    parameter int DEPTH        = 64,
    parameter int TICK_DIV     = 100_000
) (
    input  logic              clk,
    input  logic              rst_n,
    audio_sequencer_if.slave  bus
);
    localparam int         AW      = $clog2(DEPTH);
    localparam int         PSW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [1:0] CH_MASK = 2'(NUM_CHANNELS - 1);
    localparam logic [1:0] LAST_CH = 2'(NUM_CHANNELS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_WRITE   = 3'd2,
        S_WAIT    = 3'd3,
        S_SILENCE = 3'd4
    } state_t;

    typedef struct packed {
        state_t        state;
        logic [AW-1:0] step;
    } next_t;

    logic [31:0]             mem_q [DEPTH];
    logic [31:0]             rd_word_s;
    next_t                   nxt_s;
    logic                    tick_wrap_s;

    state_t                  state_q, state_d;
    logic [AW-1:0]           step_q, step_d;
    logic [PSW-1:0]          presc_q, presc_d;
    logic [12:0]             dur_q, dur_d;
    logic                    last_q, last_d;
    logic [1:0]              sil_ch_q, sil_ch_d;
    logic                    au_we_q, au_we_d;
    logic [1:0]              au_addr_q, au_addr_d;
    logic [PERIOD_WIDTH-1:0] au_data_q, au_data_d;
    logic                    busy_q, busy_d;

    // Next-entry rule shared by a finished WRITE (dur 0) and a finished WAIT.
    function automatic next_t next_entry(input logic last, input logic lp, input logic [AW-1:0] idx);
        next_t r;
        if (!last) begin
            r.state = S_FETCH;
            r.step  = idx + 1'b1;
        end else if (lp) begin
            r.state = S_FETCH;
            r.step  = '0;
        end else begin
            r.state = S_SILENCE;
            r.step  = idx;
        end
        return r;
    endfunction

    // Step-table write port; contents are deliberately kept across reset.
    always_ff @(posedge clk) begin
        if (bus.cfg_wenable) begin
            mem_q[bus.cfg_addr] <= bus.cfg_wdata;
        end
    end

    // The read word is only captured on the FETCH edge, so a same-cycle write yields old data.
    assign rd_word_s   = mem_q[step_q];
    assign nxt_s       = next_entry(last_q, bus.loop, step_q);
    assign tick_wrap_s = (presc_q == PSW'(TICK_DIV - 1));

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        presc_d  = presc_q;
        dur_d    = dur_q;
        last_d   = last_q;
        sil_ch_d = 2'd0;

        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_d = S_FETCH;
                    step_d  = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                if (bus.stop) begin
                    state_d = S_SILENCE;
                end else begin
                    state_d = S_WRITE;
                    dur_d   = rd_word_s[28:16];
                    last_d  = rd_word_s[31];
                end
            end
            S_WRITE: begin
                if (bus.stop) begin
                    state_d = S_SILENCE;
                end else if (dur_q != 13'd0) begin
                    state_d = S_WAIT;
                    presc_d = '0;
                end else begin
                    state_d = nxt_s.state;
                    step_d  = nxt_s.step;
                end
            end
            S_WAIT: begin
                if (bus.stop) begin
                    state_d = S_SILENCE;
                end else if (!tick_wrap_s) begin
                    presc_d = presc_q + 1'b1;
                end else begin
                    presc_d = '0;
                    dur_d   = dur_q - 13'd1;
                    if (dur_q == 13'd1) begin
                        state_d = nxt_s.state;
                        step_d  = nxt_s.step;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_SILENCE: begin
                if (sil_ch_q == LAST_CH) begin
                    state_d = S_IDLE;
                end else begin
                    sil_ch_d = sil_ch_q + 2'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered, so they are derived from where the FSM is heading.
        if (state_d == S_SILENCE) begin
            au_we_d   = 1'b1;
            au_addr_d = sil_ch_d;
            au_data_d = '0;
        end else if (state_d == S_WRITE) begin
            au_we_d   = 1'b1;
            au_addr_d = rd_word_s[30:29] & CH_MASK;
            au_data_d = PERIOD_WIDTH'(rd_word_s[15:0]);
        end else begin
            au_we_d   = 1'b0;
            au_addr_d = au_addr_q;
            au_data_d = au_data_q;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            step_q    <= '0;
            presc_q   <= '0;
            dur_q     <= 13'd0;
            last_q    <= 1'b0;
            sil_ch_q  <= 2'd0;
            au_we_q   <= 1'b0;
            au_addr_q <= 2'd0;
            au_data_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            presc_q   <= presc_d;
            dur_q     <= dur_d;
            last_q    <= last_d;
            sil_ch_q  <= sil_ch_d;
            au_we_q   <= au_we_d;
            au_addr_q <= au_addr_d;
            au_data_q <= au_data_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.au_wenable = au_we_q;
    assign bus.au_addr    = au_addr_q;
    assign bus.au_wdata   = au_data_q;
    assign bus.busy       = busy_q;
    assign bus.step_idx   = step_q;
endmodule

// File: tb/tb_audio_sequencer.sv
// Bench for audio_sequencer: a table-driven basic-note check, directed multi-cycle
// sequences and randomized tables, all judged against a write-list reference model.
module tb_audio_sequencer;
    localparam int NCH   = 4;
    localparam int PW    = 16;
    localparam int DEPTH = 16;
    localparam int TD    = 4;
    localparam int AW    = $clog2(DEPTH);

    typedef struct {
        int t;
        int addr;
        int data;
        int step;
    } wr_t;

    typedef struct {
        int   off;
        logic we;
        int   addr;
        int   data;
        logic busy;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   fall_cyc = -1;
    logic busy_prev = 1'b0;
    logic [31:0] tbl [DEPTH];
    wr_t  obs[$];
    wr_t  exp_q[$];

    audio_sequencer_if #(.DEPTH(DEPTH), .PERIOD_WIDTH(PW)) bus ();

    audio_sequencer #(
        .NUM_CHANNELS(NCH),
        .PERIOD_WIDTH(PW),
        .DEPTH(DEPTH),
        .TICK_DIV(TD)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Records every audio_unit write and the cycle in which busy falls.
    always @(negedge clk) begin
        if (bus.au_wenable) begin
            obs.push_back('{cyc, int'(bus.au_addr), int'(bus.au_wdata), int'(bus.step_idx)});
        end
        if (busy_prev && !bus.busy) fall_cyc = cyc;
        busy_prev = bus.busy;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got time %0t required less", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int last, input int ch, input int dur, input int per);
        return {1'(last), 2'(ch), 13'(dur), 16'(per)};
    endfunction

    // Expected writes (offsets from the start cycle) from the table rules; returns busy-fall offset.
    function automatic int model(input int lc, input int s);
        int t = 2;
        int idx = 0;
        int sst = -1;
        int it = 0;
        int d;
        logic [31:0] e;
        exp_q.delete();
        while (sst < 0 && it < 400) begin
            e = tbl[idx];
            d = int'(e[28:16]);
            exp_q.push_back('{t, int'(e[30:29]) % NCH, int'(e[15:0]), idx});
            if (!e[31]) begin
                t += (d == 0) ? 2 : d * TD + 2;
                idx = (idx + 1) % DEPTH;
            end else if (t + d * TD < lc) begin
                t += (d == 0) ? 2 : d * TD + 2;
                idx = 0;
            end else begin
                sst = t + d * TD + 1;
            end
            it++;
        end
        if (s >= 1 && s < sst) begin
            while (exp_q.size() > 0 && exp_q[exp_q.size()-1].t > s) exp_q.pop_back();
            sst = s + 1;
        end
        for (int c = 0; c < NCH; c++) exp_q.push_back('{sst + c, c, 0, -1});
        return sst + NCH;
    endfunction

    task automatic idle_inputs();
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.loop = 1'b0;
        bus.cfg_wenable = 1'b0;
    endtask

    task automatic load(input int a, input logic [31:0] d);
        tbl[a] = d;
        @(posedge clk); #1;
        bus.cfg_wenable = 1'b1;
        bus.cfg_addr = AW'(a);
        bus.cfg_wdata = d;
        @(posedge clk); #1;
        bus.cfg_wenable = 1'b0;
    endtask

    // Plays the current table: loop high for offsets < lc, stop at offset s, extra start at st2,
    // optional cfg write at offset cw; then compares every write and the busy fall.
    task automatic run_case(input string name, input int lc, input int s, input int st2,
                            input int cw, input int cw_addr, input logic [31:0] cw_data);
        int endo;
        int cs;
        if (cw >= 0) tbl[cw_addr] = cw_data;
        endo = model(lc, s);
        obs.delete();
        fall_cyc = -1;
        @(posedge clk); #1;
        cs = cyc;
        for (int k = 0; k <= endo + 2; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            bus.start = (k == 0) || (k == st2);
            bus.stop = (k == s);
            bus.loop = (k < lc);
            bus.cfg_wenable = (k == cw);
            bus.cfg_addr = AW'(cw_addr);
            bus.cfg_wdata = cw_data;
        end
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk({name, " busy idle"}, int'(bus.busy), 0);
        chk({name, " nwrites"}, obs.size(), exp_q.size());
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            chk($sformatf("%s w%0d cycle", name, i), obs[i].t - cs, exp_q[i].t);
            chk($sformatf("%s w%0d addr", name, i), obs[i].addr, exp_q[i].addr);
            chk($sformatf("%s w%0d data", name, i), obs[i].data, exp_q[i].data);
            if (exp_q[i].step >= 0) chk($sformatf("%s w%0d step", name, i), obs[i].step, exp_q[i].step);
        end
        chk({name, " busy fall"}, fall_cyc - cs, endo);
    endtask

    initial begin
        vec_t vt[10];
        int cs;
        int n;
        int lc;
        int s;
        int endo;

        vt[0] = '{0,  1'b0, 0, 0,     1'b0};
        vt[1] = '{1,  1'b0, 0, 0,     1'b1};
        vt[2] = '{2,  1'b1, 0, 10000, 1'b1};
        vt[3] = '{3,  1'b0, 0, 0,     1'b1};
        vt[4] = '{14, 1'b0, 0, 0,     1'b1};
        vt[5] = '{15, 1'b1, 0, 0,     1'b1};
        vt[6] = '{16, 1'b1, 1, 0,     1'b1};
        vt[7] = '{17, 1'b1, 2, 0,     1'b1};
        vt[8] = '{18, 1'b1, 3, 0,     1'b1};
        vt[9] = '{19, 1'b0, 0, 0,     1'b0};

        idle_inputs();
        bus.cfg_addr = '0;
        bus.cfg_wdata = 32'd0;
        #2;
        chk("reset au_wenable", int'(bus.au_wenable), 0);
        chk("reset au_addr", int'(bus.au_addr), 0);
        chk("reset au_wdata", int'(bus.au_wdata), 0);
        chk("reset busy", int'(bus.busy), 0);
        chk("reset step_idx", int'(bus.step_idx), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic note, cycle by cycle from a fixed table.
        load(0, mk(1, 0, 3, 10000));
        @(posedge clk); #1;
        bus.start = 1'b1;
        cs = cyc;
        fork
            begin
                @(posedge clk); #1;
                bus.start = 1'b0;
            end
        join_none
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            while (cyc < cs + vt[i].off) @(negedge clk);
            chk($sformatf("note off%0d we", vt[i].off), int'(bus.au_wenable), int'(vt[i].we));
            chk($sformatf("note off%0d busy", vt[i].off), int'(bus.busy), int'(vt[i].busy));
            if (vt[i].we) begin
                chk($sformatf("note off%0d addr", vt[i].off), int'(bus.au_addr), vt[i].addr);
                chk($sformatf("note off%0d data", vt[i].off), int'(bus.au_wdata), vt[i].data);
            end
        end
        repeat (3) @(posedge clk);

        // start and stop together while idle are both ignored.
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.stop = 1'b1;
        @(posedge clk); #1;
        idle_inputs();
        repeat (2) @(negedge clk);
        chk("idle start+stop busy", int'(bus.busy), 0);

        load(0, mk(0, 0, 0, 1000));
        load(1, mk(0, 1, 0, 2000));
        load(2, mk(1, 2, 2, 3000));
        run_case("chord", 0, -1, -1, -1, 0, 32'd0);

        load(0, mk(0, 1, 1, 500));
        load(1, mk(1, 2, 1, 600));
        run_case("loop", 21, -1, -1, -1, 0, 32'd0);

        load(0, mk(1, 3, 100, 777));
        run_case("stop wait", 0, 50, 52, -1, 0, 32'd0);

        load(0, mk(0, 0, 2, 111));
        load(1, mk(1, 1, 1, 222));
        run_case("tbl write", 0, -1, -1, 5, 1, mk(1, 1, 1, 999));

        // Reset in the middle of a long WAIT, then replay the retained table.
        load(0, mk(1, 3, 100, 4242));
        obs.delete();
        @(posedge clk); #1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (20) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midreset au_wenable", int'(bus.au_wenable), 0);
        chk("midreset au_addr", int'(bus.au_addr), 0);
        chk("midreset au_wdata", int'(bus.au_wdata), 0);
        chk("midreset busy", int'(bus.busy), 0);
        chk("midreset step_idx", int'(bus.step_idx), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("midreset writes", obs.size(), 1);
        run_case("replay", 0, -1, -1, -1, 0, 32'd0);

        for (int r = 0; r < 14; r++) begin
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) begin
                load(i, mk((i == n - 1) ? 1 : 0, $urandom_range(0, 3), $urandom_range(0, 3),
                           $urandom_range(1, 65535)));
            end
            lc = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 40) : 0;
            endo = model(lc, -1);
            s = ($urandom_range(0, 2) == 0) ? $urandom_range(1, endo - 1) : -1;
            run_case($sformatf("rand%0d", r), lc, s, -1, -1, 0, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/audio_sequencer.md
Name: audio_sequencer

Overview:
- Autonomous note sequencer that drives the audio_unit period registers, so the CPU does not have to write each note in software.
- The CPU loads a step table, then pulses start. The sequencer walks the table, writes a period to one audio channel per step, and waits a programmed number of ticks between steps.
- It sits between the CPU peripheral bus and audio_unit's write port. It is the only writer of audio_unit while it is busy.

Parameters:
- NUM_CHANNELS, 4, number of audio_unit channels; must be a power of two, at most 4.
- PERIOD_WIDTH, 16, width of an audio_unit period register.
- DEPTH, 64, number of step-table entries; must be a power of two.
- TICK_DIV, 100_000, clock cycles per duration tick (1 ms at 100 MHz); must be at least 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_wenable  in  1  write strobe for one step-table entry.
- cfg_addr  in  log2(DEPTH)  step-table write address.
- cfg_wdata  in  32  step entry: [31] last, [30:29] channel, [28:16] dur (ticks), [15:0] period.
- start  in  1  one-cycle pulse; begin playback at entry 0.
- stop  in  1  one-cycle pulse; abort playback and silence all channels.
- loop  in  1  level; when high, playback wraps to entry 0 after the last entry.
- au_wenable  out  1  write strobe to audio_unit.
- au_addr  out  2  audio_unit channel index.
- au_wdata  out  PERIOD_WIDTH  period written; 0 means silent.
- busy  out  1  high in every state except IDLE.
- step_idx  out  log2(DEPTH)  index of the entry currently being executed.

Behaviour:
- Reset:
  - State goes to IDLE.
  - au_wenable=0, au_addr=0, au_wdata=0, busy=0, step_idx=0, tick and duration counters cleared.
  - Step-table RAM is not reset.
  - Reset asserted mid-playback drops straight to IDLE. No silence writes are issued; audio_unit is reset by the same rst_n.
- Step table:
  - Synchronous-read RAM with one write port (cfg) and one read port (sequencer).
  - cfg writes are accepted in any state.
  - A read and a write to the same address in the same cycle return the old data.
- FSM states: IDLE, FETCH, WRITE, WAIT, SILENCE.
  - IDLE: start pulse sets step_idx=0 and moves to FETCH. stop in IDLE is ignored.
  - FETCH: one cycle. Issues the RAM read of step_idx, then moves to WRITE.
  - WRITE: one cycle. au_wenable=1, au_addr=channel, au_wdata=period. au_wenable is high for exactly this one cycle per entry.
    - dur != 0: go to WAIT and clear the tick counters.
    - dur == 0 and last == 0: step_idx+1, then FETCH. This is used to build chords.
    - dur == 0 and last == 1: handled as end-of-table (see below).
  - WAIT: stays for exactly dur*TICK_DIV cycles. The prescaler counts 0..TICK_DIV-1; the duration counter decrements on each prescaler wrap. After that it applies the next-entry rule.
  - End-of-table and next-entry rule:
    - last == 0: step_idx+1, go to FETCH. step_idx wraps from DEPTH-1 to 0 naturally.
    - last == 1 and loop == 1: step_idx=0, go to FETCH.
    - last == 1 and loop == 0: go to SILENCE.
  - SILENCE: writes period 0 to channels 0..NUM_CHANNELS-1 in ascending order, one per cycle with au_wenable=1, then goes to IDLE. busy drops in the cycle after the final write.
- Start-to-write latency: start sampled in cycle 0 gives au_wenable=1 in cycle 2.
- Entry-to-entry spacing: with dur=d > 0, consecutive au_wenable pulses are d*TICK_DIV+2 cycles apart. With dur=0 they are 2 cycles apart.
- stop in FETCH, WRITE or WAIT:
  - The next cycle enters SILENCE at channel 0.
  - A WRITE that coincides with stop still completes.
- stop during SILENCE is ignored; the sweep continues.
- start while busy is ignored. If start and stop arrive in the same cycle, stop wins; when IDLE, both are ignored.
- channel bits >= NUM_CHANNELS are masked to log2(NUM_CHANNELS) bits.

Test Plan:
- Basic note (TICK_DIV=4). Entry0 = {last=1, ch=0, dur=3, period=10000}, loop=0, pulse start:
  - au_wenable at +2 with addr 0, data 10000.
  - After 12 WAIT cycles, four silence writes to ch0..3 with data 0.
  - busy falls after the ch3 write.
- Chord. Entries {ch0, dur0, 1000}, {ch1, dur0, 2000}, {ch2, dur2, 3000, last}:
  - Writes arrive 2 cycles apart: ch0, ch1, ch2.
  - Then 8 WAIT cycles, then the silence sweep.
- Loop. Two entries with last on entry 1 and loop=1:
  - step_idx sequence is 0,1,0,1….
  - Dropping loop before the last entry ends playback with a silence sweep.
- Stop mid-WAIT:
  - Pulse stop during a dur=100 wait; the next cycle starts the silence sweep, 4 writes.
  - A start pulsed during the sweep is ignored; busy=0 afterwards.
- Reset mid-playback:
  - Assert rst_n=0 during WAIT; all outputs go to 0 immediately with no au_wenable.
  - After release, a start pulse replays the table, whose contents are retained.
- Table write during playback:
  - Rewrite entry 1 while entry 0 is waiting; the new period is written when entry 1 executes.
